cmd_queue: RTL

Command queue at the responder end of the issuer's queue interface. It answers the issuer's read requests (`issuer_rd_queue`) by returning the next command on `queue_cmd` with a one-cycle `queue_ack`. It also answers write-back requests (`issuer_wr_queue`/`issuer_cmd`), which re-insert a dependency-stalled command at the head. A host load port fills the tail from the program loader. It sits between the loader and the issuer inside `top`.

---
 rtl/cmd_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cmd_queue.sv
// Responder-side command queue: host loads fill the tail, the issuer reads from the head
// and may write a stalled command back in front of the head; every issuer transaction gets a one-cycle ack.
module cmd_queue #(
  parameter int DEPTH = 16,
  parameter int CMD_W = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_rd,
  input  logic                         i_wr,
  input  logic [CMD_W-1:0]             i_cmd,
  output logic [CMD_W-1:0]             o_cmd,
  output logic                         o_ack,
  input  logic                         i_load_valid,
  input  logic [CMD_W-1:0]             i_load_cmd,
  output logic                         o_load_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [CMD_W-1:0]   mem [DEPTH];

  logic               wb_acc;
  logic               rd_acc;
  logic               load_acc;
  logic               load_room;
  logic [AW-1:0]      wb_addr;

  assign wb_addr = rd_ptr_q - PTR_ONE;

  // Issuer FSM decision, load acceptance and next-state computation.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    wb_acc    = 1'b0;
    rd_acc    = 1'b0;
    case (state_q)
      IDLE: begin
        // A blocked write-back never falls through to a read.
        if (i_wr) begin
          if (count_q != DEPTH_C) begin
            wb_acc  = 1'b1;
            state_d = ACK;
          end else begin
            state_d = IDLE;
          end
        end else if (i_rd) begin
          if (count_q != COUNT_ZERO) begin
            rd_acc  = 1'b1;
            cmd_d   = mem[rd_ptr_q];
            state_d = ACK;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    load_room    = (count_q + CW'(wb_acc)) < DEPTH_C;
    o_load_ready = ~i_rst & load_room;
    load_acc     = i_load_valid & o_load_ready;

    if (wb_acc) begin
      rd_ptr_d = wb_addr;
    end else if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    wr_ptr_d = wr_ptr_q + AW'(load_acc);
    count_d  = count_q + CW'(load_acc) + CW'(wb_acc) - CW'(rd_acc);
  end

  // State, pointer, occupancy and output-command registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= COUNT_ZERO;
      cmd_q    <= {CMD_W{1'b0}};
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
    end
  end

  // Command storage; slots never coincide because a load is refused whenever wb would fill the last slot.
  always_ff @(posedge i_clk) begin
    if (wb_acc) begin
      mem[wb_addr] <= i_cmd;
    end
    if (load_acc) begin
      mem[wr_ptr_q] <= i_load_cmd;
    end
  end

  assign o_cmd   = cmd_q;
  assign o_ack   = (state_q == ACK);
  assign o_count = count_q;
  assign o_empty = (count_q == COUNT_ZERO);
  assign o_full  = (count_q == DEPTH_C);

endmodule
